// File: rtl/apb_regfile.sv
// APB3 slave register bank: windowed word decode with PSLVERR, programmable wait states,
// per-register one-cycle write strobes and a saturating error counter for debug.
module apb_regfile #(
  parameter logic [31:0] START_ADDRESS = 32'h8c000000,
  parameter int          N_REGS        = 255,
  parameter int          WAIT_STATES   = 0,
  parameter int          ERR_CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PADDR,
  input  logic [31:0]             PWDATA,
  output logic [31:0]             PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [32*N_REGS-1:0]    regs_out,
  output logic [N_REGS-1:0]       reg_wr_pulse,
  output logic [ERR_CNT_W-1:0]    err_count
);
  localparam int          IDX_W        = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int          TABLE_N      = 2 ** IDX_W;
  localparam logic [31:0] LAST_ADDRESS = START_ADDRESS + 32'(4 * (N_REGS - 1));
  localparam logic [4:0]  WAIT_INIT    = 5'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_reg, state_next;

  logic [4:0]           wcnt_reg;
  logic                 addr_err_reg;
  logic                 write_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [31:0]          prdata_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic                 setup;
  logic                 complete;
  logic                 commit_wr;
  logic                 addr_err;
  logic [31:0]          offset;
  logic [IDX_W-1:0]     idx;
  logic                 unused_offset_bits;
  logic [31:0]          rd_table [TABLE_N];

  assign setup  = (state_reg == IDLE) && PSEL && !PENABLE;
  assign offset = PADDR - START_ADDRESS;
  assign idx    = offset[IDX_W+1:2];
  // The index is only meaningful inside the window, so the high offset bits never matter.
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};
  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR < START_ADDRESS) || (PADDR > LAST_ADDRESS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (PSEL && !PENABLE) state_next = ACCESS;
      ACCESS:  if (!PSEL || complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs come from registered state only; APB inputs just qualify completion.
  always_comb begin
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    complete  = 1'b0;
    commit_wr = 1'b0;
    if (state_reg == ACCESS && wcnt_reg == 5'd0) begin
      PREADY    = 1'b1;
      PSLVERR   = addr_err_reg;
      complete  = PSEL && PENABLE;
      commit_wr = PSEL && PENABLE && write_reg && !addr_err_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_reg     <= 5'd0;
      addr_err_reg <= 1'b0;
      write_reg    <= 1'b0;
      idx_reg      <= '0;
      prdata_reg   <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (setup) begin
        wcnt_reg     <= WAIT_INIT;
        addr_err_reg <= addr_err;
        write_reg    <= PWRITE;
        idx_reg      <= idx;
        prdata_reg   <= (PWRITE || addr_err) ? 32'h0 : rd_table[idx];
      end else if (state_reg == ACCESS && PENABLE && wcnt_reg != 5'd0) begin
        wcnt_reg <= wcnt_reg - 5'd1;
      end
      if (complete && addr_err_reg && !(&err_cnt_reg)) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end

  assign PRDATA    = prdata_reg;
  assign err_count = err_cnt_reg;

  // Read table is padded to a power of two so every index value selects a defined word.
  genvar gi;
  generate
    for (gi = 0; gi < TABLE_N; gi++) begin : g_reg
      if (gi < N_REGS) begin : g_live
        logic [31:0] value_reg;
        logic        pulse_reg;
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            value_reg <= '0;
            pulse_reg <= 1'b0;
          end else begin
            pulse_reg <= commit_wr && (idx_reg == IDX_W'(gi));
            if (commit_wr && (idx_reg == IDX_W'(gi))) begin
              value_reg <= PWDATA;
            end
          end
        end
        assign regs_out[32*gi +: 32] = value_reg;
        assign reg_wr_pulse[gi]      = pulse_reg;
        assign rd_table[gi]          = value_reg;
      end else begin : g_pad
        assign rd_table[gi] = 32'h0;
      end
    end
  endgenerate
endmodule

// File: tb/tb_apb_regfile.sv
// Bench for apb_regfile: two instances (default, and 3 wait states / 2-bit error counter)
// share one APB master; a transaction-level model predicts every output each cycle.
module tb_apb_regfile;
  localparam logic [31:0] BASE = 32'h8c000000;
  localparam int N0 = 255;
  localparam int N1 = 8;
  localparam int W1 = 3;
  localparam int RW0 = 32 * N0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  int cur;
  logic psel0, psel1;
  assign psel0 = psel && (cur == 0);
  assign psel1 = psel && (cur == 1);

  logic [31:0]      prdata0, prdata1;
  logic             pready0, pready1, pslverr0, pslverr1;
  logic [32*N0-1:0] regs0;
  logic [32*N1-1:0] regs1;
  logic [N0-1:0]    pulse0;
  logic [N1-1:0]    pulse1;
  logic [15:0]      errc0;
  logic [1:0]       errc1;

  apb_regfile dut0 (
    .clk(clk), .rst_n(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
    .regs_out(regs0), .reg_wr_pulse(pulse0), .err_count(errc0)
  );

  apb_regfile #(.START_ADDRESS(BASE), .N_REGS(N1), .WAIT_STATES(W1), .ERR_CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .regs_out(regs1), .reg_wr_pulse(pulse1), .err_count(errc1)
  );

  // Behavioural model
  logic [31:0] mem [2][N0];
  int          nregs [2] = '{N0, N1};
  int          waits [2] = '{0, W1};
  int          errmax [2] = '{65535, 3};
  int          merr [2];
  logic [31:0] mprd [2];
  int          mpulse [2];
  bit          exp_pready, exp_pslverr, checking;
  int          vectors, miscompares;
  int          last_len;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic rdy, input logic slv, input logic [31:0] prd,
                         input logic [RW0-1:0] regs, input logic [N0-1:0] pulse, input logic [15:0] ec);
    logic [N0-1:0] ep;
    int bad;
    chk($sformatf("dut%0d PREADY", d), 128'(rdy), 128'((cur == d) ? exp_pready : 1'b0));
    chk($sformatf("dut%0d PSLVERR", d), 128'(slv), 128'((cur == d) ? exp_pslverr : 1'b0));
    chk($sformatf("dut%0d PRDATA", d), 128'(prd), 128'(mprd[d]));
    chk($sformatf("dut%0d err_count", d), 128'(ec), 128'(merr[d]));
    ep = '0;
    if (mpulse[d] >= 0) ep[mpulse[d]] = 1'b1;
    vectors++;
    if (pulse !== ep) begin
      miscompares++;
      $display("FAIL dut%0d reg_wr_pulse: got %h expected %h", d, pulse, ep);
    end
    bad = -1;
    for (int i = 0; i < nregs[d]; i++)
      if (bad < 0 && regs[32*i +: 32] !== mem[d][i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL dut%0d regs_out[%0d]: got %h expected %h", d, bad, regs[32*bad +: 32], mem[d][bad]);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp_dut(0, pready0, pslverr0, prdata0, regs0, pulse0, errc0);
      cmp_dut(1, pready1, pslverr1, prdata1, RW0'(regs1), N0'(pulse1), 16'(errc1));
    end
  end

  function automatic bit model_err(input int d, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (a > BASE + 32'(4 * (nregs[d] - 1)));
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N0; i++) mem[d][i] = 32'h0;
      merr[d] = 0;
      mprd[d] = 32'h0;
      mpulse[d] = -1;
    end
    exp_pready = 1'b0;
    exp_pslverr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mpulse[0] = -1;
    mpulse[1] = -1;
  endtask

  // One APB transfer; abort_at = access cycle in which PSEL is dropped (-1 = none).
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] data,
                      input int abort_at);
    bit err;
    int idx;
    err = model_err(d, a);
    idx = int'((a - BASE) >> 2);
    cur = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = data;
    exp_pready = 1'b0; exp_pslverr = 1'b0;
    tick();
    mprd[d] = 32'h0;
    if (!wr && !err) mprd[d] = mem[d][idx];
    penable = 1'b1;
    last_len = 0;
    for (int k = 0; k <= waits[d]; k++) begin
      exp_pready = (k == waits[d]);
      exp_pslverr = exp_pready && err;
      if (k == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        tick();
        exp_pready = 1'b0; exp_pslverr = 1'b0;
        return;
      end
      if (last_len == 0 && ((d == 0) ? pready0 : pready1)) last_len = k + 2;
      tick();
    end
    psel = 1'b0; penable = 1'b0;
    exp_pready = 1'b0; exp_pslverr = 1'b0;
    if (wr && !err) begin
      mem[d][idx] = data;
      mpulse[d] = idx;
    end
    if (err && merr[d] < errmax[d]) merr[d]++;
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    int d, sel, ridx, abort;
    logic [31:0] a;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; cur = 0;
    checking = 1'b0; vectors = 0; miscompares = 0; last_len = 0;
    model_clear();
    tick();
    checking = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Write then read, no wait states
    xfer(0, 1'b1, BASE + 32'h4, 32'h12345678, -1);
    chk("w0_len", 128'(last_len), 128'd2);
    chk("w0_reg1", 128'(regs0[63:32]), 128'h12345678);
    chk("w0_pulse", 128'(pulse0[31:0]), 128'h2);
    xfer(0, 1'b0, BASE + 32'h4, 32'h0, -1);
    chk("r0_data", 128'(prdata0), 128'h12345678);

    // Three wait states: five cycles including setup
    xfer(1, 1'b0, BASE, 32'h0, -1);
    chk("ws3_len", 128'(last_len), 128'd5);

    // Window boundaries
    xfer(0, 1'b1, BASE + 32'h3f8, 32'hA5A5A5A5, -1);
    chk("top_reg254", 128'(regs0[32*254 +: 32]), 128'hA5A5A5A5);
    xfer(0, 1'b1, BASE + 32'h3fc, 32'h11111111, -1);
    xfer(0, 1'b1, 32'h8bffff00, 32'h22222222, -1);
    chk("oob_errcnt", 128'(errc0), 128'd2);
    xfer(0, 1'b0, BASE + 32'h2, 32'h0, -1);
    chk("misalign_rd", 128'(prdata0), 128'h0);

    // Saturating 2-bit error counter
    for (int i = 0; i < 5; i++) begin
      xfer(1, 1'b0, BASE + 32'h1, 32'h0, -1);
      chk($sformatf("sat_%0d", i), 128'(errc1), 128'(sat_exp[i]));
    end

    // Abort during a wait state
    xfer(1, 1'b1, BASE + 32'h8, 32'hDEADBEEF, 1);
    chk("abort_pulse", 128'(pulse1), 128'h0);
    chk("abort_reg2", 128'(regs1[95:64]), 128'h0);
    xfer(1, 1'b1, BASE + 32'h8, 32'h0000BEEF, -1);
    chk("post_abort_reg2", 128'(regs1[95:64]), 128'hBEEF);

    // Back-to-back writes
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, BASE + 32'(4 * i), 32'(i + 1), -1);
      chk($sformatf("b2b_pulse%0d", i), 128'(pulse0[3:0]), 128'(1 << i));
    end
    chk("b2b_regs", regs0[127:0], 128'h00000004_00000003_00000002_00000001);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      d = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      ridx = $urandom_range(0, nregs[d] - 1);
      if (sel <= 6) a = BASE + 32'(4 * ridx);
      else if (sel == 7) a = BASE + 32'(4 * ridx) + 32'($urandom_range(1, 3));
      else if (sel == 8) a = BASE - 32'(4 * $urandom_range(1, 64));
      else a = BASE + 32'(4 * nregs[d]) + 32'(4 * $urandom_range(0, 64));
      abort = -1;
      if (waits[d] > 0 && $urandom_range(0, 9) == 0) abort = $urandom_range(0, waits[d] - 1);
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, abort);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of an access phase
    cur = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'hC; pwdata = 32'h55;
    exp_pready = 1'b0; exp_pslverr = 1'b0;
    tick();
    mprd[1] = 32'h0;
    penable = 1'b1;
    rst_n = 1'b0;
    tick();
    model_clear();
    psel = 1'b0; penable = 1'b0;
    chk("rst_pready", 128'(pready1), 128'h0);
    chk("rst_errc0", 128'(errc0), 128'h0);
    chk("rst_reg0", 128'(regs0[31:0]), 128'h0);
    rst_n = 1'b1;
    tick();
    xfer(1, 1'b1, BASE + 32'hC, 32'h77, -1);
    chk("post_rst_reg3", 128'(regs1[127:96]), 128'h77);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
